// File: rtl/mc_bypass_fifo_arb_if.sv
// Stream interface for mc_bypass_fifo_arb: per-channel write ports, the merged
// valid/ready output stream and the per-channel status flags.
interface mc_bypass_fifo_arb_if #(
  parameter int CH_NUM = 4,
  parameter int WIDTH  = 64
);
  localparam int CH_W = $clog2(CH_NUM);

  logic [CH_NUM-1:0]       i_WrEn;
  logic [CH_NUM*WIDTH-1:0] i_WrData;
  logic [CH_NUM-1:0]       o_Full;
  logic [CH_NUM-1:0]       o_Overflow;
  logic                    o_Valid;
  logic [WIDTH-1:0]        o_Data;
  logic [CH_W-1:0]         o_Ch;
  logic                    i_Ready;

  modport slave (
    input  i_WrEn, i_WrData, i_Ready,
    output o_Full, o_Overflow, o_Valid, o_Data, o_Ch
  );

  modport master (
    output i_WrEn, i_WrData, i_Ready,
    input  o_Full, o_Overflow, o_Valid, o_Data, o_Ch
  );
endinterface

// File: rtl/mc_bypass_fifo_arb.sv
// Per-channel FIFOs merged by a round-robin arbiter into one registered,
// channel-tagged valid/ready stream. Define MCFIFO_BYPASS_EN for the empty-FIFO bypass path.
module mc_bypass_fifo_arb #(
  parameter int CH_NUM = 4,
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 64
) (
  input logic                  CLK,
  input logic                  Reset,
  mc_bypass_fifo_arb_if.slave  bus
);
  localparam int CH_W  = $clog2(CH_NUM);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              load;
  logic [CH_NUM-1:0] empty, full, wr_acc, req, pop, byp, push;
  logic [WIDTH-1:0]  head_data [CH_NUM];
  logic              gnt_any;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   last_reg;
  logic              valid_reg;
  logic [WIDTH-1:0]  data_reg;
  logic [CH_W-1:0]   ch_reg;

  assign load = !valid_reg || bus.i_Ready;

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic             ovf_reg;
      logic [WIDTH-1:0] wr_data;
      logic             granted;

      assign wr_data    = bus.i_WrData[gi*WIDTH +: WIDTH];
      assign empty[gi]  = (count_reg == '0);
      assign full[gi]   = (count_reg == CNT_W'(DEPTH));
      assign wr_acc[gi] = bus.i_WrEn[gi] && !full[gi];
      assign granted    = load && gnt_any && (gnt_idx == CH_W'(gi));

`ifdef MCFIFO_BYPASS_EN
      // An empty channel with an incoming word may request; if granted the
      // word skips the FIFO and goes straight to the output register.
      assign req[gi]       = !empty[gi] || wr_acc[gi];
      assign byp[gi]       = granted && empty[gi];
      assign head_data[gi] = empty[gi] ? wr_data : mem[rd_ptr_reg];
`else
      assign req[gi]       = !empty[gi];
      assign byp[gi]       = 1'b0;
      assign head_data[gi] = mem[rd_ptr_reg];
`endif

      assign pop[gi]  = granted && !empty[gi];
      assign push[gi] = wr_acc[gi] && !byp[gi];

      always_ff @(posedge CLK) begin
        if (push[gi])
          mem[wr_ptr_reg] <= wr_data;
      end

      always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
          ovf_reg    <= 1'b0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
          // Dropped write: full is judged before any same-cycle pop.
          if (bus.i_WrEn[gi] && full[gi])
            ovf_reg <= 1'b1;
        end
      end

      assign bus.o_Overflow[gi] = ovf_reg;
    end
  endgenerate

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      cand = (int'(last_reg) + i) % CH_NUM;
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(cand);
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ch_reg    <= '0;
      last_reg  <= CH_W'(CH_NUM - 1);
    end else if (load) begin
      valid_reg <= gnt_any;
      if (gnt_any) begin
        data_reg <= head_data[gnt_idx];
        ch_reg   <= gnt_idx;
        last_reg <= gnt_idx;
      end
    end
  end

  assign bus.o_Full  = full;
  assign bus.o_Valid = valid_reg;
  assign bus.o_Data  = data_reg;
  assign bus.o_Ch    = ch_reg;
endmodule

// File: tb/tb_mc_bypass_fifo_arb.sv
// Self-checking bench for mc_bypass_fifo_arb: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_mc_bypass_fifo_arb;
  localparam int CH    = 4;
  localparam int DEPTH = 8;
  localparam int W     = 64;
  localparam int CH_W  = 2;
`ifdef MCFIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic Reset = 1'b1;

  mc_bypass_fifo_arb_if #(.CH_NUM(CH), .WIDTH(W)) bus ();

  mc_bypass_fifo_arb #(.CH_NUM(CH), .DEPTH(DEPTH), .WIDTH(W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int exp_lat;

  // Reference model: one queue per channel plus the output slot.
  logic [W-1:0]    mq [CH][$];
  logic            m_valid;
  logic [W-1:0]    m_data;
  logic [CH_W-1:0] m_ch;
  int              m_last;
  logic [CH-1:0]   m_ovf;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = '0;
    m_last  = CH - 1;
    m_ovf   = '0;
  endtask

  task automatic model_step();
    logic [CH-1:0] acc;
    int g;
    acc = '0;
    g   = -1;
    for (int c = 0; c < CH; c++) begin
      acc[c] = bus.i_WrEn[c] && (mq[c].size() < DEPTH);
      if (bus.i_WrEn[c] && mq[c].size() == DEPTH) m_ovf[c] = 1'b1;
    end
    if (!m_valid || bus.i_Ready) begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (m_last + k) % CH;
        if (g < 0 && (mq[c].size() > 0 || (BYP && acc[c]))) g = c;
      end
      if (g < 0) begin
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_ch    = CH_W'(g);
        m_last  = g;
        if (mq[g].size() > 0) begin
          m_data = mq[g].pop_front();
        end else begin
          m_data = bus.i_WrData[g*W +: W];
          acc[g] = 1'b0;
        end
      end
    end
    for (int c = 0; c < CH; c++)
      if (acc[c]) mq[c].push_back(bus.i_WrData[c*W +: W]);
  endtask

  function automatic logic [CH*W-1:0] one_ch(input int c, input logic [W-1:0] v);
    logic [CH*W-1:0] r;
    r = '0;
    r[c*W +: W] = v;
    return r;
  endfunction

  task automatic tick(input logic [CH-1:0] we, input logic [CH*W-1:0] wd, input logic rdy);
    bus.i_WrEn   = we;
    bus.i_WrData = wd;
    bus.i_Ready  = rdy;
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    bus.i_WrEn = '0; bus.i_WrData = '0; bus.i_Ready = 1'b0;
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.i_WrEn = '0; bus.i_WrData = '0; bus.i_Ready = 1'b0;
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    assert_cnt++; if (bus.o_Valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %b want 0", bus.o_Valid); end
    assert_cnt++; if (bus.o_Data !== '0) begin fail_cnt++; $display("FAIL reset_data: got %h want 0", bus.o_Data); end
    assert_cnt++; if (bus.o_Ch !== '0) begin fail_cnt++; $display("FAIL reset_ch: got %0d want 0", bus.o_Ch); end
    assert_cnt++; if (bus.o_Full !== '0) begin fail_cnt++; $display("FAIL reset_full: got %b want 0", bus.o_Full); end
    assert_cnt++; if (bus.o_Overflow !== '0) begin fail_cnt++; $display("FAIL reset_ovf: got %b want 0", bus.o_Overflow); end
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_bypass();
    int first;
    do_reset();
    first = 0;
    for (int n = 1; n <= 4 && first == 0; n++) begin
      if (n == 1) tick(4'b0100, one_ch(2, 64'hA5), 1'b1);
      else        tick('0, '0, 1'b1);
      if (bus.o_Valid === 1'b1) first = n;
    end
    assert_cnt++; if (first != exp_lat) begin fail_cnt++; $display("FAIL bypass_latency: got %0d want %0d", first, exp_lat); end
    assert_cnt++; if (bus.o_Data !== 64'hA5) begin fail_cnt++; $display("FAIL bypass_data: got %h want a5", bus.o_Data); end
    assert_cnt++; if (bus.o_Ch !== 2'd2) begin fail_cnt++; $display("FAIL bypass_ch: got %0d want 2", bus.o_Ch); end
    tick('0, '0, 1'b1);
    assert_cnt++; if (bus.o_Valid !== 1'b0) begin fail_cnt++; $display("FAIL bypass_drain: got %b want 0", bus.o_Valid); end
    $display("bypass: latency %0d cycles", first);
  endtask

  task automatic test_round_robin();
    logic [CH*W-1:0] wd;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      wd = '0;
      for (int c = 0; c < CH; c++) wd[c*W +: W] = W'(c * 256 + k);
      tick(4'hF, wd, 1'b0);
    end
    for (int i = 0; i < 2 * CH; i++) begin
      assert_cnt++; if (bus.o_Valid !== 1'b1) begin fail_cnt++; $display("FAIL rr_valid[%0d]: got %b want 1", i, bus.o_Valid); end
      assert_cnt++; if (bus.o_Ch !== CH_W'(i % CH)) begin fail_cnt++; $display("FAIL rr_ch[%0d]: got %0d want %0d", i, bus.o_Ch, i % CH); end
      assert_cnt++; if (bus.o_Data !== W'((i % CH) * 256 + i / CH)) begin fail_cnt++; $display("FAIL rr_data[%0d]: got %h want %h", i, bus.o_Data, (i % CH) * 256 + i / CH); end
      $display("round_robin: beat %0d ch %0d data %h", i, bus.o_Ch, bus.o_Data);
      tick('0, '0, 1'b1);
    end
    assert_cnt++; if (bus.o_Valid !== 1'b0) begin fail_cnt++; $display("FAIL rr_end: got %b want 0", bus.o_Valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(4'b0001, one_ch(0, 64'hCAFE), 1'b0);
    tick('0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick((k < 3) ? 4'b0010 : 4'b0000, one_ch(1, 64'h1000 + 64'(k)), 1'b0);
      assert_cnt++; if (bus.o_Valid !== 1'b1 || bus.o_Data !== 64'hCAFE || bus.o_Ch !== 2'd0) begin
        fail_cnt++; $display("FAIL bp_hold[%0d]: got v%b %h ch%0d want v1 cafe ch0", k, bus.o_Valid, bus.o_Data, bus.o_Ch);
      end
      $display("backpressure: hold cycle %0d data %h", k, bus.o_Data);
    end
    tick('0, '0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      assert_cnt++; if (bus.o_Valid !== 1'b1 || bus.o_Ch !== 2'd1 || bus.o_Data !== 64'h1000 + 64'(j)) begin
        fail_cnt++; $display("FAIL bp_drain[%0d]: got v%b %h ch%0d want v1 %h ch1", j, bus.o_Valid, bus.o_Data, bus.o_Ch, 64'h1000 + 64'(j));
      end
      tick('0, '0, 1'b1);
    end
    assert_cnt++; if (bus.o_Valid !== 1'b0) begin fail_cnt++; $display("FAIL bp_end: got %b want 0", bus.o_Valid); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      tick(4'b0001, one_ch(0, W'(i)), 1'b0);
      assert_cnt++; if (bus.o_Full[0] !== (i == DEPTH)) begin fail_cnt++; $display("FAIL full_rise[%0d]: got %b want %b", i, bus.o_Full[0], i == DEPTH); end
    end
    assert_cnt++; if (bus.o_Overflow[0] !== 1'b0) begin fail_cnt++; $display("FAIL ovf_early: got %b want 0", bus.o_Overflow[0]); end
    tick(4'b0001, one_ch(0, W'(DEPTH + 1)), 1'b0);
    assert_cnt++; if (bus.o_Overflow !== 4'b0001) begin fail_cnt++; $display("FAIL ovf_set: got %b want 0001", bus.o_Overflow); end
    for (int i = 0; i <= DEPTH; i++) begin
      assert_cnt++; if (bus.o_Valid !== 1'b1 || bus.o_Data !== W'(i)) begin fail_cnt++; $display("FAIL full_drain[%0d]: got v%b %h want v1 %h", i, bus.o_Valid, bus.o_Data, i); end
      tick('0, '0, 1'b1);
      if (i == 0) begin
        assert_cnt++; if (bus.o_Full[0] !== 1'b0) begin fail_cnt++; $display("FAIL full_fall: got %b want 0", bus.o_Full[0]); end
      end
    end
    assert_cnt++; if (bus.o_Valid !== 1'b0) begin fail_cnt++; $display("FAIL full_end: got %b want 0 (dropped word leaked)", bus.o_Valid); end
    assert_cnt++; if (bus.o_Overflow[0] !== 1'b1) begin fail_cnt++; $display("FAIL ovf_sticky: got %b want 1", bus.o_Overflow[0]); end
    $display("full_overflow: drained %0d words, overflow %b", DEPTH + 1, bus.o_Overflow);
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int i = 0; i < 5; i++) tick(4'b1000, one_ch(3, 64'h30 + 64'(i)), 1'b0);
    assert_cnt++; if (bus.o_Data !== 64'h30 || bus.o_Ch !== 2'd3) begin fail_cnt++; $display("FAIL pp_head: got %h ch%0d want 30 ch3", bus.o_Data, bus.o_Ch); end
    tick(4'b1000, one_ch(3, 64'h35), 1'b1);
    for (int j = 1; j <= 5; j++) begin
      assert_cnt++; if (bus.o_Valid !== 1'b1 || bus.o_Ch !== 2'd3 || bus.o_Data !== 64'h30 + 64'(j)) begin
        fail_cnt++; $display("FAIL pp_order[%0d]: got v%b %h ch%0d want v1 %h ch3", j, bus.o_Valid, bus.o_Data, bus.o_Ch, 64'h30 + 64'(j));
      end
      tick('0, '0, 1'b1);
    end
    assert_cnt++; if (bus.o_Valid !== 1'b0) begin fail_cnt++; $display("FAIL pp_end: got %b want 0", bus.o_Valid); end
  endtask

  task automatic test_random();
    logic [CH*W-1:0] wd;
    logic [CH-1:0]   we;
    logic            rdy;
    int              errs;
    do_reset();
    errs = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      we = 4'($urandom) & 4'($urandom);
      for (int c = 0; c < CH; c++) wd[c*W +: W] = {$urandom, $urandom};
      rdy = ((cyc / 150) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick(we, wd, rdy);
      assert_cnt++; if (bus.o_Valid !== m_valid) begin fail_cnt++; errs++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus.o_Valid, m_valid); end
      if (m_valid) begin
        assert_cnt++; if (bus.o_Data !== m_data || bus.o_Ch !== m_ch) begin fail_cnt++; errs++; $display("FAIL rnd_data@%0d: got %h ch%0d want %h ch%0d", cyc, bus.o_Data, bus.o_Ch, m_data, m_ch); end
      end
      for (int c = 0; c < CH; c++) begin
        assert_cnt++; if (bus.o_Full[c] !== (mq[c].size() == DEPTH)) begin fail_cnt++; errs++; $display("FAIL rnd_full@%0d ch%0d: got %b want %b", cyc, c, bus.o_Full[c], mq[c].size() == DEPTH); end
      end
      assert_cnt++; if (bus.o_Overflow !== m_ovf) begin fail_cnt++; errs++; $display("FAIL rnd_ovf@%0d: got %b want %b", cyc, bus.o_Overflow, m_ovf); end
    end
    $display("random: 1500 cycles, %0d mismatching checks", errs);
  endtask

  task automatic test_reset_midstream();
    logic [CH*W-1:0] wd;
    int first;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < CH; c++) wd[c*W +: W] = {$urandom, $urandom};
      tick(4'hF, wd, 1'b0);
    end
    assert_cnt++; if (bus.o_Valid !== 1'b1 || bus.o_Full !== '0 && 1'b0) begin fail_cnt++; $display("FAIL mid_pre: got v%b want v1", bus.o_Valid); end
    #2;
    Reset = 1'b1;
    #1;
    assert_cnt++; if (bus.o_Valid !== 1'b0 || bus.o_Data !== '0 || bus.o_Ch !== '0) begin
      fail_cnt++; $display("FAIL mid_reset_out: got v%b %h ch%0d want v0 0 ch0", bus.o_Valid, bus.o_Data, bus.o_Ch);
    end
    assert_cnt++; if (bus.o_Full !== '0 || bus.o_Overflow !== '0) begin fail_cnt++; $display("FAIL mid_reset_flags: got full %b ovf %b want 0 0", bus.o_Full, bus.o_Overflow); end
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    model_reset();
    first = 0;
    for (int n = 1; n <= 4 && first == 0; n++) begin
      if (n == 1) tick(4'hF, wd, 1'b1);
      else        tick('0, '0, 1'b0);
      if (bus.o_Valid === 1'b1) first = n;
    end
    assert_cnt++; if (first != exp_lat || bus.o_Ch !== 2'd0) begin fail_cnt++; $display("FAIL mid_first_grant: got lat %0d ch%0d want lat %0d ch0", first, bus.o_Ch, exp_lat); end
    $display("reset_midstream: first grant ch %0d", bus.o_Ch);
  endtask

  initial begin
    exp_lat = BYP ? 1 : 2;
    model_reset();
    test_reset();
    test_bypass();
    test_round_robin();
    test_backpressure();
    test_full_overflow();
    test_push_pop();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mc_bypass_fifo_arb.md
# mc_bypass_fifo_arb

Multi-channel successor to the single-channel bypass FIFO. It has CH_NUM independent per-channel synchronous FIFOs, a built-in round-robin arbiter and one registered output stage. Together these merge all channels into a single valid/ready stream tagged with the channel ID. Compared with the single-channel block, it adds:
- true downstream backpressure;
- full flags with overflow detection;
- guaranteed per-channel FIFO order when a write and a read hit the same channel in the same cycle.

## Interface
- CH_NUM, 4, number of input channels, ≥2.
- DEPTH, 8, entries per channel FIFO, power of 2, ≥2.
- WIDTH, 64, data width.
- CLK  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- i_WrEn  input  CH_NUM  per-channel write strobe.
- i_WrData  input  CH_NUM*WIDTH  per-channel write data; channel c occupies bits [c*WIDTH +: WIDTH].
- o_Full  output  CH_NUM  channel FIFO full (count==DEPTH); combinational from registered count.
- o_Overflow  output  CH_NUM  sticky flag, set when a write hits a full channel.
- o_Valid  output  1  output register holds valid data.
- o_Data  output  WIDTH  output data; registered.
- o_Ch  output  $clog2(CH_NUM)  source channel of o_Data; registered.
- i_Ready  input  1  downstream accepts o_Data this cycle.

## Operation
- Write acceptance:
  - A write on channel c is accepted iff i_WrEn[c] && !o_Full[c].
  - A write to a full channel is dropped, even if that channel is popped in the same cycle. o_Overflow[c] is set next edge and held until Reset.
- Output load: the output register loads when load = !o_Valid || i_Ready.
- Request: req[c] = !empty[c] || (accepted write on c && empty[c]). The second term is the bypass request.
- Arbitration:
  - Round-robin, one-hot grant, evaluated only when load=1.
  - The search starts at last+1 modulo CH_NUM. `last` updates to the granted channel only on a load that carries a grant.
- Granted channel, FIFO non-empty:
  - Pop the FIFO head into the output register.
  - An accepted write on the same channel in the same cycle is pushed normally, so the count is unchanged. FIFO order is preserved.
- Granted channel, FIFO empty with an accepted write (bypass):
  - i_WrData goes straight into the output register. The FIFO is not written and its count stays 0.
- Accepted write, not bypassed (not granted, or FIFO non-empty): pushed into the channel FIFO.
- Load with no request: o_Valid clears to 0 (the held data was consumed).
- load=0 (o_Valid && !i_Ready): o_Valid, o_Data and o_Ch hold stable, and no pop occurs.
- Counts and pointers:
  - Per-channel count is $clog2(DEPTH)+1 bits wide.
  - Read/write pointers are $clog2(DEPTH) bits and wrap naturally.
  - empty = (count==0), full = (count==DEPTH).

## Timing
- Reset values (asynchronous):
  - o_Valid=0, o_Data=0, o_Ch=0, o_Overflow=0.
  - All counts and pointers 0, so o_Full=0.
  - last=CH_NUM-1, so channel 0 wins first.
- Bypass latency: write at edge t gives o_Valid=1 with that data after edge t+1. That is 1 cycle.
- FIFO-path latency: a write stored at edge t can appear on the output at t+2 at the earliest.
- Throughput: 1 word/cycle aggregate while i_Ready=1.
- Fairness: with all channels requesting continuously, grants rotate 0,1,…,CH_NUM-1,0,…
- o_Full[c] rises the cycle after the DEPTH-th resident word is stored. It falls the cycle after a pop from a full FIFO.
- Reset asserted mid-transfer: all state is discarded immediately. In-flight o_Data is lost and no handshake completes.

## Configuration
- MCFIFO_BYPASS_EN:
  - Defined: the bypass path exists, giving 1-cycle latency on an empty channel.
  - Undefined: req[c] = !empty[c] only. Every accepted write is pushed into the FIFO, giving a minimum latency of 2 cycles. Ordering, arbitration and the full/overflow rules are unchanged.

## Test plan
- Bypass: Reset, i_Ready=1, single write ch2 data 0xA5 at t → o_Valid=1, o_Data=0xA5, o_Ch=2 at t+1. Ch2 count stays 0. With MCFIFO_BYPASS_EN undefined, the same word appears at t+2.
- Round-robin: preload 2 words in each of ch0..ch3, i_Ready=1 → o_Ch sequence 0,1,2,3,0,1,2,3, then o_Valid=0.
- Backpressure: o_Valid=1 with i_Ready=0 for 5 cycles while ch1 writes 3 words → o_Data/o_Ch stable for all 5 cycles. Ch1 count=3. Releasing i_Ready drains in write order.
- Full/overflow: i_Ready=0, write 9 words 0..8 on ch0 (DEPTH=8) → word 0 held in the output register, words 1..8 fill the FIFO. o_Full[0]=1 once the 8th resident word (word 8) is stored. Then write word 9 → dropped and o_Overflow[0]=1. After draining, the sequence is 0..8 with no 9.
- Simultaneous push/pop: ch3 count=4, granted pop with a same-cycle write → count stays 4, and the output order is the old head first, new word last.
- Reset mid-stream: assert Reset with o_Valid=1 and counts non-zero → all outputs 0 and o_Full=0 asynchronously. The first post-reset grant goes to ch0.
